// File: rtl/fpu_pkg.sv
// Shared types, flag positions, command codes and special-value patterns for the fpu
// execution units.
package fpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StDone
    } state_e;

    localparam int unsigned FlagInvalid   = 3;
    localparam int unsigned FlagOverflow  = 2;
    localparam int unsigned FlagUnderflow = 1;
    localparam int unsigned FlagInexact   = 0;

    localparam logic [3:0] CmdAdd = 4'h1;
    localparam logic [3:0] CmdSub = 4'h2;

    // Patterns are built 64 bits wide; callers keep the low 1+exp_w+man_w bits.
    function automatic logic [63:0] qnan_pat(input int unsigned exp_w, input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] inf_pat(input logic sign, input int unsigned exp_w,
                                            input int unsigned man_w);
        return (64'(sign) << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

    function automatic logic [63:0] zero_pat(input logic sign, input int unsigned exp_w,
                                             input int unsigned man_w);
        return 64'(sign) << (exp_w + man_w);
    endfunction

    function automatic logic [3:0] mk_flags(input logic inv, input logic ovf, input logic unf,
                                            input logic inx);
        logic [3:0] f;
        f                = '0;
        f[FlagInvalid]   = inv;
        f[FlagOverflow]  = ovf;
        f[FlagUnderflow] = unf;
        f[FlagInexact]   = inx;
        return f;
    endfunction

endpackage

// File: rtl/fpu_round.sv
// Round-to-nearest-even on a normalised mantissa with guard/round/sticky bits.
module fpu_round
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                    [MAN_W:0]   man,
    input  logic                                guard,
    input  logic                                round,
    input  logic                                sticky,
    input  logic signed             [EXP_W+1:0] exp,
    output logic                    [MAN_W-1:0] frac,
    output logic                    [EXP_W-1:0] exp_out,
    output logic                                overflow,
    output logic                                inexact
);
    localparam int unsigned EW = EXP_W + 2;
    localparam logic signed [EW-1:0] ExpOne = EW'(1);
    localparam logic signed [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);

    logic                 round_up;
    logic [MAN_W+1:0]     man_rnd;
    logic signed [EW-1:0] exp_rnd;

    always_comb begin
        inexact  = guard | round | sticky;
        round_up = guard & (round | sticky | man[0]);
        man_rnd  = {1'b0, man} + {{(MAN_W + 1){1'b0}}, round_up};
        // Rounding 1.11..1 up carries into a new leading bit.
        if (man_rnd[MAN_W+1]) begin
            frac    = man_rnd[MAN_W:1];
            exp_rnd = exp + ExpOne;
        end else begin
            frac    = man_rnd[MAN_W-1:0];
            exp_rnd = exp;
        end
        overflow = exp_rnd >= ExpMax;
        exp_out  = exp_rnd[EXP_W-1:0];
    end

endmodule

// File: rtl/fpu_addsub.sv
// Multi-cycle parametrised floating-point add/subtract unit with ready/ack handshakes,
// denormal flush, special-value handling and round-to-nearest-even.
module fpu_addsub
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   input_rdy,
    output logic                   input_ack,
    input  logic [EXP_W+MAN_W:0]   data_a,
    input  logic [EXP_W+MAN_W:0]   data_b,
    input  logic                   sub,
    output logic                   output_rdy,
    input  logic                   output_ack,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned MW = MAN_W + 4;
    localparam int unsigned SW = MAN_W + 5;
    localparam logic signed [EW-1:0] ExpOne   = EW'(1);
    localparam logic        [EW-1:0] MaxShift = EW'(MAN_W + 3);
    localparam logic [63:0] QnanW = qnan_pat(EXP_W, MAN_W);
    localparam logic [63:0] InfW  = inf_pat(1'b0, EXP_W, MAN_W);
    localparam logic [63:0] ZeroW = zero_pat(1'b0, EXP_W, MAN_W);

    state_e               state_q, state_d;
    logic [W-1:0]         op_a_q, op_b_q, result_q;
    logic [3:0]           flags_q;
    logic                 sign_a_q, sign_b_q, special_q;
    logic signed [EW-1:0] exp_a_q, exp_b_q;
    logic [MW-1:0]        man_a_q, man_b_q;
    logic [SW-1:0]        sum_q;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap, is_special;
    logic [W-1:0]     spec_result;
    logic [3:0]       spec_flags;
    logic [MW-1:0]    man_a_u, man_b_u;

    assign ea = op_a_q[W-2:MAN_W];
    assign eb = op_b_q[W-2:MAN_W];
    assign fa = op_a_q[MAN_W-1:0];
    assign fb = op_b_q[MAN_W-1:0];

    always_comb begin
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        a_inf   = (&ea) && (fa == '0);
        b_inf   = (&eb) && (fb == '0);
        a_nan   = (&ea) && (fa != '0);
        b_nan   = (&eb) && (fb != '0);
        swap    = op_b_q[W-2:0] > op_a_q[W-2:0];
        man_a_u = a_zero ? '0 : {1'b1, fa, 3'b000};
        man_b_u = b_zero ? '0 : {1'b1, fb, 3'b000};
        is_special  = 1'b1;
        spec_result = '0;
        spec_flags  = '0;
        if (a_nan || b_nan) begin
            spec_result = QnanW[W-1:0];
        end else if (a_inf && b_inf && (op_a_q[W-1] != op_b_q[W-1])) begin
            spec_result = QnanW[W-1:0];
            spec_flags  = mk_flags(1'b1, 1'b0, 1'b0, 1'b0);
        end else if (a_inf) begin
            spec_result = {op_a_q[W-1], InfW[W-2:0]};
        end else if (b_inf) begin
            spec_result = {op_b_q[W-1], InfW[W-2:0]};
        end else if (a_zero && b_zero) begin
            spec_result = {op_a_q[W-1] & op_b_q[W-1], ZeroW[W-2:0]};
        end else begin
            is_special = 1'b0;
        end
    end

    logic [EW-1:0] diff;
    logic [MW-1:0] shifted, lost_mask, aligned;
    logic [SW-1:0] sum;
    logic          carry, hidden, exp_min;

    always_comb begin
        diff      = exp_a_q - exp_b_q;
        shifted   = man_b_q >> diff;
        lost_mask = ~({MW{1'b1}} << diff);
        if (diff >= MaxShift) begin
            aligned = {{(MW - 1){1'b0}}, |man_b_q};
        end else begin
            aligned = {shifted[MW-1:1], shifted[0] | (|(man_b_q & lost_mask))};
        end
        // The swap guarantees |A| >= |B|, so the difference never goes negative.
        sum     = (sign_a_q == sign_b_q) ? {1'b0, man_a_q} + {1'b0, man_b_q}
                                         : {1'b0, man_a_q} - {1'b0, man_b_q};
        carry   = sum_q[SW-1];
        hidden  = sum_q[SW-2];
        exp_min = (exp_a_q == ExpOne);
    end

    logic [MAN_W-1:0] rnd_frac;
    logic [EXP_W-1:0] rnd_exp;
    logic             rnd_ovf, rnd_inexact;

    fpu_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .man      (sum_q[SW-2:3]),
        .guard    (sum_q[2]),
        .round    (sum_q[1]),
        .sticky   (sum_q[0]),
        .exp      (exp_a_q),
        .frac     (rnd_frac),
        .exp_out  (rnd_exp),
        .overflow (rnd_ovf),
        .inexact  (rnd_inexact)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (input_rdy) state_d = StUnpack;
            StUnpack: state_d = StAlign;
            // Special operands are classified in UNPACK and leave from here.
            StAlign:  state_d = special_q ? StDone : StAdd;
            StAdd:    state_d = (sum == '0) ? StDone : StNorm;
            StNorm: begin
                if (carry || hidden) state_d = StRound;
                else if (exp_min)    state_d = StDone;
            end
            StRound:  state_d = StDone;
            StDone:   if (output_ack) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        input_ack  = (state_q == StIdle);
        output_rdy = (state_q == StDone);
        result     = result_q;
        flags      = flags_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            special_q <= 1'b0;
            exp_a_q   <= '0;
            exp_b_q   <= '0;
            man_a_q   <= '0;
            man_b_q   <= '0;
            sum_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (input_rdy) begin
                    op_a_q <= data_a;
                    op_b_q <= {data_b[W-1] ^ sub, data_b[W-2:0]};
                end
                StUnpack: begin
                    special_q <= is_special;
                    if (is_special) begin
                        result_q <= spec_result;
                        flags_q  <= spec_flags;
                    end
                    sign_a_q <= swap ? op_b_q[W-1] : op_a_q[W-1];
                    sign_b_q <= swap ? op_a_q[W-1] : op_b_q[W-1];
                    exp_a_q  <= swap ? {2'b00, eb} : {2'b00, ea};
                    exp_b_q  <= swap ? {2'b00, ea} : {2'b00, eb};
                    man_a_q  <= swap ? man_b_u : man_a_u;
                    man_b_q  <= swap ? man_a_u : man_b_u;
                end
                StAlign: if (!special_q) man_b_q <= aligned;
                StAdd: begin
                    sum_q <= sum;
                    if (sum == '0) begin
                        result_q <= '0;
                        flags_q  <= '0;
                    end
                end
                StNorm: begin
                    if (carry) begin
                        sum_q   <= {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
                        exp_a_q <= exp_a_q + ExpOne;
                    end else if (!hidden && exp_min) begin
                        result_q <= {sign_a_q, ZeroW[W-2:0]};
                        flags_q  <= mk_flags(1'b0, 1'b0, 1'b1, 1'b1);
                    end else if (!hidden) begin
                        sum_q   <= {sum_q[SW-2:0], 1'b0};
                        exp_a_q <= exp_a_q - ExpOne;
                    end
                end
                StRound: begin
                    if (rnd_ovf) begin
                        result_q <= {sign_a_q, InfW[W-2:0]};
                        flags_q  <= mk_flags(1'b0, 1'b1, 1'b0, 1'b1);
                    end else begin
                        result_q <= {sign_a_q, rnd_exp, rnd_frac};
                        flags_q  <= mk_flags(1'b0, 1'b0, 1'b0, rnd_inexact);
                    end
                end
                StDone: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub.sv
// Directed-vector bench for fpu_addsub: single- and half-precision instances.
module tb_fpu_addsub;

    logic        clock = 1'b0;
    logic        reset;
    logic        input_rdy, input_ack, sub, output_rdy, output_ack;
    logic [31:0] data_a, data_b, result;
    logic [3:0]  flags;

    logic        h_input_rdy, h_input_ack, h_sub, h_output_rdy, h_output_ack;
    logic [15:0] h_data_a, h_data_b, h_result;
    logic [3:0]  h_flags;

    always #5 clock = ~clock;

    fpu_addsub #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .input_rdy  (input_rdy),
        .input_ack  (input_ack),
        .data_a     (data_a),
        .data_b     (data_b),
        .sub        (sub),
        .output_rdy (output_rdy),
        .output_ack (output_ack),
        .result     (result),
        .flags      (flags)
    );

    fpu_addsub #(
        .EXP_W (5),
        .MAN_W (10)
    ) dut_h (
        .clock      (clock),
        .reset      (reset),
        .input_rdy  (h_input_rdy),
        .input_ack  (h_input_ack),
        .data_a     (h_data_a),
        .data_b     (h_data_b),
        .sub        (h_sub),
        .output_rdy (h_output_rdy),
        .output_ack (h_output_ack),
        .result     (h_result),
        .flags      (h_flags)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Waits for output_rdy (bounded); lat counts edges after the accept edge.
    task automatic wait_done(input string tag, output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!output_rdy && lat < 100) begin
            if (input_ack) busy_ok = 1'b0;
            @(posedge clock);
            #1 lat++;
        end
        if (input_ack) busy_ok = 1'b0;
        check({tag, "_rdy"}, 32'(output_rdy), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, output logic [31:0] res, output logic [3:0] fl,
                          output int lat, output logic busy_ok);
        @(negedge clock);
        data_a    = a;
        data_b    = b;
        sub       = s;
        input_rdy = 1'b1;
        @(posedge clock);
        #1 input_rdy = 1'b0;
        wait_done(tag, lat, busy_ok);
        res = result;
        fl  = flags;
        @(negedge clock);
        output_ack = 1'b1;
        @(posedge clock);
        #1 output_ack = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] res, hold;
        logic [3:0]  fl;
        int          lat;
        logic        busy, stable;

        reset        = 1'b1;
        input_rdy    = 1'b0;
        output_ack   = 1'b0;
        sub          = 1'b0;
        data_a       = '0;
        data_b       = '0;
        h_input_rdy  = 1'b0;
        h_output_ack = 1'b0;
        h_sub        = 1'b0;
        h_data_a     = '0;
        h_data_b     = '0;
        #1;
        check("rst_input_ack", 32'(input_ack), 32'd1);
        check("rst_output_rdy", 32'(output_rdy), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // 1.0 + 0.01: aligned by 7, sticky set, no normalise steps.
        run_op("small", 32'h3F800000, 32'h3C23D70A, 1'b0, res, fl, lat, busy);
        check("small_res", res, 32'h3F8147AE);
        check("small_flags", 32'(fl), 32'h1);
        check("small_lat", lat, 32'd5);
        check("small_busy", 32'(busy), 32'd1);

        // 26 + 29 = 55: carry-out normalise.
        run_op("carry", 32'h41D00000, 32'h41E80000, 1'b0, res, fl, lat, busy);
        check("carry_res", res, 32'h425C0000);
        check("carry_flags", 32'(fl), 32'h0);
        check("carry_lat", lat, 32'd5);

        run_op("cancel", 32'h3F800000, 32'h3F800000, 1'b1, res, fl, lat, busy);
        check("cancel_res", res, 32'h00000000);
        check("cancel_flags", 32'(fl), 32'h0);

        // 1.0 + 2^-24: exact tie, stays even.
        run_op("tie", 32'h3F800000, 32'h33800000, 1'b0, res, fl, lat, busy);
        check("tie_res", res, 32'h3F800000);
        check("tie_flags", 32'(fl), 32'h1);

        run_op("inf_inf", 32'h7F800000, 32'hFF800000, 1'b0, res, fl, lat, busy);
        check("inf_inf_res", res, 32'h7FC00000);
        check("inf_inf_flags", 32'(fl), 32'h8);
        check("inf_inf_lat", lat, 32'd2);

        run_op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, res, fl, lat, busy);
        check("ovf_res", res, 32'h7F800000);
        check("ovf_flags", 32'(fl), 32'h5);

        run_op("neg_zero", 32'h80000000, 32'h00000000, 1'b1, res, fl, lat, busy);
        check("neg_zero_res", res, 32'h80000000);

        // Backpressure: 1 + 2 held for 10 cycles; input_rdy stays high with new operands.
        @(negedge clock);
        data_a    = 32'h3F800000;
        data_b    = 32'h40000000;
        sub       = 1'b0;
        input_rdy = 1'b1;
        @(posedge clock);
        #1;
        data_a = 32'h40000000;
        data_b = 32'h40000000;
        wait_done("bp", lat, busy);
        hold   = result;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clock);
            #1 if (!output_rdy || result !== hold || input_ack) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_res", hold, 32'h40400000);
        @(negedge clock);
        output_ack = 1'b1;
        @(posedge clock);
        #1 output_ack = 1'b0;
        check("bp_release_rdy", 32'(output_rdy), 32'd0);
        check("bp_release_ack", 32'(input_ack), 32'd1);
        @(posedge clock);
        #1 input_rdy = 1'b0;
        check("bp_accept", 32'(input_ack), 32'd0);
        wait_done("bp_next", lat, busy);
        check("bp_next_res", result, 32'h40800000);
        @(negedge clock);
        output_ack = 1'b1;
        @(posedge clock);
        #1 output_ack = 1'b0;

        // Reset pulse in the middle of a long left normalise.
        @(negedge clock);
        data_a    = 32'h3F800001;
        data_b    = 32'h3F800000;
        sub       = 1'b1;
        input_rdy = 1'b1;
        @(posedge clock);
        #1 input_rdy = 1'b0;
        repeat (6) @(posedge clock);
        #2;
        check("rst_mid_busy", 32'(input_ack), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_mid_ack", 32'(input_ack), 32'd1);
        check("rst_mid_rdy", 32'(output_rdy), 32'd0);
        check("rst_mid_res", result, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        run_op("long_norm", 32'h3F800001, 32'h3F800000, 1'b1, res, fl, lat, busy);
        check("long_norm_res", res, 32'h34000000);
        check("long_norm_flags", 32'(fl), 32'h0);
        check("long_norm_lat", lat, 32'd28);

        // Half-precision instance: 1.0 + 1.0.
        @(negedge clock);
        h_data_a    = 16'h3C00;
        h_data_b    = 16'h3C00;
        h_sub       = 1'b0;
        h_input_rdy = 1'b1;
        @(posedge clock);
        #1 h_input_rdy = 1'b0;
        lat = 0;
        while (!h_output_rdy && lat < 100) begin
            @(posedge clock);
            #1 lat++;
        end
        check("half_rdy", 32'(h_output_rdy), 32'd1);
        check("half_res", 32'(h_result), 32'h4000);
        check("half_flags", 32'(h_flags), 32'h0);
        check("half_lat", lat, 32'd5);
        @(negedge clock);
        h_output_ack = 1'b1;
        @(posedge clock);
        #1 h_output_ack = 1'b0;
        check("half_idle", 32'(h_input_ack), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_addsub.md
Name: fpu_addsub

Overview:
- Parametrised multi-cycle floating-point adder/subtractor with configurable exponent and mantissa widths. It succeeds the fixed single-precision add path in the fpu.
- Adds a subtract mode, round-to-nearest-even, special-value handling (zero/inf/NaN) and exception flags.
- Uses the fpu's two-sided ready/ack handshake, so it plugs into the fpu command dispatcher as the ADD/SUB execution unit.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- input_rdy  in  1  producer has valid data_a/data_b/sub.
- input_ack  out  1  block can accept; high only in IDLE.
- data_a  in  W  left operand.
- data_b  in  W  right operand.
- sub  in  1  0: a+b, 1: a-b (flip sign of b).
- output_rdy  out  1  result/flags valid.
- output_ack  in  1  consumer has taken result.
- result  out  W  IEEE-style packed result.
- flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset values:
  - state=IDLE, input_ack=1, output_rdy=0, result=0, flags=0.
  - Asserting reset in any state aborts the operation immediately; no partial result is ever presented.
- Accept:
  - On a rising edge with input_rdy && input_ack, operands are latched and sign_b ^= sub.
  - The state moves to UNPACK.
  - input_ack drops in the next cycle and stays low until the return to IDLE.
- UNPACK (1 cycle):
  - Inputs with exp==0 are treated as zero (denormals flushed).
  - Special-case checks, each going straight to DONE:
    - Any NaN → qNaN (sign 0, exp all-ones, fraction MSB 1), invalid=0.
    - inf + (-inf) → qNaN, invalid=1.
    - Exactly one inf → that inf.
    - Both zero → +0, except (-0)+(-0) → -0.
  - Otherwise the operands are swapped so |A| ≥ |B|, with the hidden bit restored.
- ALIGN (1 cycle):
  - Shift B's mantissa right by expA-expB into a MAN_W+4 bit field: hidden + fraction + guard, round, sticky.
  - Sticky is the OR of all bits shifted out.
  - A shift ≥ MAN_W+3 gives B=0 with sticky = (B≠0).
- ADD (1 cycle):
  - Signs equal: add, with a carry bit giving MAN_W+5 bits.
  - Signs differ: A−B, which is never negative because of the swap.
  - A zero magnitude → +0, go to DONE.
- NORM (≥1 cycle):
  - On carry-out: shift right 1 with sticky preserved, exp+1, one cycle.
  - Otherwise shift left 1 bit per cycle, exp−1, until the hidden bit is 1; at most MAN_W+2 cycles.
  - If exp would reach 0: result ±0, underflow=1, inexact=1, go to DONE.
- ROUND (1 cycle):
  - Round to nearest, ties to even, using G/R/S; inexact=G|R|S.
  - Mantissa overflow after rounding → shift right, exp+1.
  - exp ≥ all-ones → ±inf, overflow=1, inexact=1.
- DONE:
  - output_rdy=1; result and flags are held stable.
  - On an edge with output_ack=1: output_rdy←0, state←IDLE, input_ack←1.
  - output_ack high at the same edge that raises output_rdy has no effect.
  - Back-to-back accept is possible on the edge after returning to IDLE.
- Latency (accept edge to output_rdy): 5 + n cycles, where n = left-normalise steps (0..MAN_W+2). Special cases take 2 cycles.
- Exponent arithmetic uses EXP_W+2 signed bits internally to detect overflow/underflow.

Decomposition:
- Package fpu_pkg holds:
  - state enum (IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE);
  - flag bit indices (FLAG_INVALID=3 … FLAG_INEXACT=0);
  - fpu command codes (CMD_ADD, CMD_SUB);
  - functions for qNaN/inf/zero patterns parametrised by EXP_W/MAN_W.
- Sub-module fpu_round: combinational RNE unit taking mantissa+G/R/S and exponent, returning the rounded mantissa, exponent, and overflow/inexact flags.

Test Plan:
- 0x3F800000 + 0x3C23D70A, sub=0 → result 0x3F8147AE, output_rdy after 5+n cycles, input_ack low while busy.
- 0x41D00000 + 0x41E80000 (26+29) → 0x425C0000 (carry normalise), flags=0.
- 0x3F800000 − 0x3F800000 → 0x00000000 (+0), flags=0; then 0x3F800000 + 0x33800000 (tie) → 0x3F800000, inexact=1.
- 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1, latency 2; 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow|inexact.
- Backpressure: hold output_ack=0 for 10 cycles → output_rdy and result stable, input_rdy ignored; ack → IDLE next edge, new operand accepted the following edge.
- Reset pulse during NORM (0x3F800001 − 0x3F800000, long normalise) → output_rdy=0, input_ack=1 immediately; the next operation completes correctly. Repeat with EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000.
